// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encoding, FSM state constants and the step-counter width helper.
package multdiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // The step counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multdiv_iterative_if.sv
// Request/result bundle between the datapath (master) and the
// multiply/divide unit (slave).
interface multdiv_iterative_if #(parameter int WIDTH = 32);

  logic             validIn;
  logic [1:0]       op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             flush;
  logic             busy;
  logic             validOut;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             divZero;

  modport master (
    output validIn, op, SrcA, SrcB, flush,
    input  busy, validOut, Hi, Lo, divZero
  );

  modport slave (
    input  validIn, op, SrcA, SrcB, flush,
    output busy, validOut, Hi, Lo, divZero
  );

endinterface

// File: rtl/multdiv_negate.sv
// Conditional two's-complement negation, used for operand absolute values
// and for restoring the sign of results.
module multdiv_negate #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/multdiv_iterative.sv
// Iterative multiply/divide unit, one result bit per cycle.
// Define MULTDIV_DIV_EN to build the restoring divider; without it divide
// ops complete with the same latency and return zero.
module multdiv_iterative
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset_n,
  multdiv_iterative_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state;
  logic [CW-1:0]      step;
  logic               div_q;
  logic               neg_res_q;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               div_zero_q;

  logic               is_signed;
  logic               is_div;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign is_div    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);

  multdiv_negate #(.WIDTH(WIDTH)) u_abs_a (
    .din(bus.SrcA), .neg(is_signed & bus.SrcA[WIDTH-1]), .dout(a_abs));
  multdiv_negate #(.WIDTH(WIDTH)) u_abs_b (
    .din(bus.SrcB), .neg(is_signed & bus.SrcB[WIDTH-1]), .dout(b_abs));
  multdiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .din(acc), .neg(neg_res_q), .dout(prod_fix));

`ifdef MULTDIV_DIV_EN
  logic               neg_rem_q;
  logic               dz_q;
  logic [WIDTH-1:0]   src_a_q;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  multdiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .din(acc[WIDTH-1:0]), .neg(neg_res_q), .dout(quo_fix));
  multdiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .din(acc[2*WIDTH-1:WIDTH]), .neg(neg_rem_q), .dout(rem_fix));

  // Extra state needed only by the divider: raw dividend, zero-divisor flag, remainder sign.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      src_a_q   <= '0;
    end else if (state == ST_IDLE && bus.validIn && !bus.flush) begin
      neg_rem_q <= is_signed & bus.SrcA[WIDTH-1];
      dz_q      <= is_div && (bus.SrcB == '0);
      src_a_q   <= bus.SrcA;
    end
  end
`endif

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULTDIV_DIV_EN
    div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, operand};
    if (div_diff[WIDTH+1])
      div_next = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`else
    div_next = acc;
`endif
  end

  // Control FSM plus accumulator and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      step       <= '0;
      div_q      <= 1'b0;
      neg_res_q  <= 1'b0;
      operand    <= '0;
      acc        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else if (state != ST_IDLE && bus.flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.validIn && !bus.flush) begin
            state     <= ST_CALC;
            step      <= '0;
            div_q     <= is_div;
            neg_res_q <= is_signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
            operand   <= is_div ? b_abs : a_abs;
            acc       <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
          end
        end
        ST_CALC: begin
          if (step == CW'(WIDTH)) begin
            state <= ST_FIX;
          end else begin
            step <= step + 1'b1;
            acc  <= div_q ? div_next : mul_next;
          end
        end
        ST_FIX: begin
          state <= ST_DONE;
          if (!div_q) begin
            {hi_q, lo_q} <= prod_fix;
            div_zero_q   <= 1'b0;
          end else begin
`ifdef MULTDIV_DIV_EN
            if (dz_q) begin
              lo_q <= '1;
              hi_q <= src_a_q;
            end else begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
            div_zero_q <= dz_q;
`else
            lo_q       <= '0;
            hi_q       <= '0;
            div_zero_q <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.validOut = (state == ST_DONE);
  assign bus.Hi       = hi_q;
  assign bus.Lo       = lo_q;
  assign bus.divZero  = div_zero_q;

endmodule
